jtframe_cen_meter: RTL
======================

Name: jtframe_cen_meter

Overview:
- Measures a clock-enable pulse train on the 48 MHz system clock, i.e. the receiving end of the clock-enable generators.
- Over a fixed window of clk cycles it counts cen pulses, tracks the minimum and maximum inter-pulse gap, and flags rates outside an expected range or a missing cen.
- Used in debug/OSD paths and simulation monitors to confirm that derived enables (6, 3.57, 0.384 MHz, ...) run at the intended rate and jitter.

Parameters:
WINLEN, 48000, window length in clk cycles (1 ms at 48 MHz); must be ≥2
CNTW, 16, width of the pulse counter and of freq
GAPW, 8, width of the gap counters and of gap_min/gap_max
EXP_MIN, 0, lowest acceptable pulses per window
EXP_MAX, 65535, highest acceptable pulses per window

Ports:
clk  input  1  system clock, 48 MHz
rst_n  input  1  asynchronous active-low reset
en  input  1  measurement enable; low forces IDLE
cen  input  1  clock enable under test, sampled every clk
freq  output  CNTW  cen pulses counted in the last completed window
gap_min  output  GAPW  smallest gap in clk cycles seen in the last window
gap_max  output  GAPW  largest gap seen in the last window
valid  output  1  one-cycle strobe: freq, gap_min, gap_max, stuck and bad just updated
stuck  output  1  last window contained no cen
bad  output  1  last freq < EXP_MIN or > EXP_MAX
armed  output  1  high while in MEASURE

Behaviour:
- Reset is asynchronous and active-low: clk, rst_n.
  - All outputs and all internal counters go to 0.
  - State goes to IDLE.
  - Deassertion takes effect on the next clk edge.
- States:
  - IDLE: entered on reset or whenever en=0.
    - Counters are cleared.
    - freq, gap_min, gap_max, stuck and bad hold their last values.
    - en=1 moves to ARM.
  - ARM: waits for the first cen=1.
    - That cen cycle is not counted.
    - It clears the gap counter and the window counter, and moves to MEASURE.
    - With no cen the block stays in ARM indefinitely and valid never pulses.
  - MEASURE: each cycle the window counter increments from 0 to WINLEN-1, then wraps to 0.
    - The window is the WINLEN cycles following the arming cen.
    - The block stays in MEASURE across windows; it does not re-arm.
    - en=0 at any cycle aborts to IDLE: no valid, no output update.
- Gap counting:
  - The gap counter increments every cycle and saturates at 2^GAPW-1.
  - On cen=1 the measured gap is counter+1, saturating at 2^GAPW-1. The counter is then reset to 0.
  - A cen every N cycles therefore measures N. cen held high measures 1.
- Window statistics:
  - On each cen in MEASURE the pulse count increments and saturates at 2^CNTW-1.
  - The running min and max gap are updated.
  - The running min starts at all-ones and the running max at 0 for each window.
- Window end (cycle with window count WINLEN-1):
  - A cen in this cycle is included.
  - On the next edge, freq, gap_min and gap_max take the final values. valid=1 for exactly one cycle.
  - stuck = (count==0). If stuck, gap_min and gap_max are reported as 0.
  - bad = (count<EXP_MIN) || (count>EXP_MAX).
  - The running count, min and max reset for the new window. The gap counter is NOT reset, so gaps spanning a window boundary are measured correctly and attributed to the window in which they end.
- Latency:
  - Results appear 1 cycle after the last window cycle.
  - armed is registered and rises 1 cycle after the arming cen.
- Simultaneous events:
  - en=0 in the window-end cycle: abort wins, no valid.
  - Saturation of the count and the gap in the same cycle is independent.

Test Plan:
- WINLEN=48, cen 1-in-4 after arm → valid every 48 cycles; freq=12, gap_min=gap_max=4, stuck=0.
- WINLEN=1408, cen gaps alternating 13/14 (3.57 MHz pattern) → freq=104 or 105, gap_min=13, gap_max=14.
- WINLEN=48, cen held high → freq=48, gap_min=gap_max=1; with EXP_MAX=40, bad=1.
- Arm, then cen stops → next window: valid=1, freq=0, stuck=1, gap_min=gap_max=0. Later windows repeat until cen returns.
- GAPW=8, cen every 300 cycles, WINLEN=1000 → gap_max=255 (saturated).
- Drop en mid-window → valid never pulses, outputs keep prior values, state returns to ARM when en=1. Pulse rst_n low mid-window → all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/jtframe_cen_meter.sv
// jtframe_cen_meter: measures pulse rate and inter-pulse gap range of a clock enable over fixed windows
module jtframe_cen_meter #(
    parameter int WINLEN  = 48000,
    parameter int CNTW    = 16,
    parameter int GAPW    = 8,
    parameter int EXP_MIN = 0,
    parameter int EXP_MAX = 65535
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            cen,
    output logic [CNTW-1:0] freq,
    output logic [GAPW-1:0] gap_min,
    output logic [GAPW-1:0] gap_max,
    output logic            valid,
    output logic            stuck,
    output logic            bad,
    output logic            armed
);
    localparam int WW = $clog2(WINLEN);
    localparam logic [WW-1:0] WLAST = WW'(WINLEN - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t          r_state, w_next;
    logic [WW-1:0]   r_win;
    logic [GAPW-1:0] r_gap, r_min, r_max, r_gmin, r_gmax;
    logic [CNTW-1:0] r_cnt, r_freq;
    logic            r_valid, r_stuck, r_bad;
    logic [GAPW-1:0] w_gap, w_min, w_max;
    logic [CNTW-1:0] w_cnt;
    logic            w_run, w_last, w_stuck, w_bad;

    // w_gap doubles as the next idle count and as the gap measured by a cen this cycle
    assign w_run   = en && (r_state == MEASURE);
    assign w_last  = r_win == WLAST;
    assign w_gap   = &r_gap ? r_gap : r_gap + GAPW'(1);
    assign w_cnt   = !cen || &r_cnt ? r_cnt : r_cnt + CNTW'(1);
    assign w_min   = cen && (w_gap < r_min) ? w_gap : r_min;
    assign w_max   = cen && (w_gap > r_max) ? w_gap : r_max;
    assign w_stuck = w_cnt == '0;
    assign w_bad   = (int'(w_cnt) < EXP_MIN) || (int'(w_cnt) > EXP_MAX);

    assign freq    = r_freq;
    assign gap_min = r_gmin;
    assign gap_max = r_gmax;
    assign valid   = r_valid;
    assign stuck   = r_stuck;
    assign bad     = r_bad;
    assign armed   = r_state == MEASURE;

    // next state: en low always aborts, ARM waits for the first cen, MEASURE never re-arms
    always_comb begin
        w_next = !en ? IDLE : (r_state == IDLE) ? ARM : (r_state == ARM && !cen) ? ARM : MEASURE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // window counters and result registers; the gap counter keeps running across window ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win   <= '0;
            r_gap   <= '0;
            r_cnt   <= '0;
            r_min   <= '0;
            r_max   <= '0;
            r_freq  <= '0;
            r_gmin  <= '0;
            r_gmax  <= '0;
            r_valid <= 1'b0;
            r_stuck <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            r_valid <= w_run && w_last;
            r_win   <= !w_run || w_last ? '0 : r_win + WW'(1);
            r_gap   <= !w_run || cen ? '0 : w_gap;
            r_cnt   <= !w_run || w_last ? '0 : w_cnt;
            r_min   <= !w_run || w_last ? '1 : w_min;
            r_max   <= !w_run || w_last ? '0 : w_max;
            if (w_run && w_last) begin
                r_freq  <= w_cnt;
                r_gmin  <= w_stuck ? '0 : w_min;
                r_gmax  <= w_stuck ? '0 : w_max;
                r_stuck <= w_stuck;
                r_bad   <= w_bad;
            end
        end
    end
endmodule
